code_loader: RTL
================

# code_loader

Boot-time program loader that drives the write port of the core's code memory. It consumes the byte stream from the UART receiver: a 4-byte big-endian word count N, then N instruction words of 4 bytes each, big-endian. It emits one `we`/`addr`/`w_data` write per assembled word, with addresses 0, 1, 2, … in arrival order. When the last word has been written it raises `done`, which releases the core from reset.

## Interface

Parameters:
- CODE_SIZE, 32767 — highest valid word address of the code memory. Depth is CODE_SIZE+1 words.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_valid  input  1  one-cycle strobe; rx_data holds a received byte
- rx_data  input  8  received byte
- we  output  1  code-memory write enable; one-cycle pulse per word
- addr  output  32  code-memory word address
- w_data  output  32  assembled instruction word
- busy  output  1  high from the first header byte until done
- done  output  1  load complete; held high until reset
- overflow  output  1  sticky; N exceeded CODE_SIZE+1

## Operation

- State machine: HEADER → DATA → DONE.
- A 2-bit byte counter and a 32-bit shift register assemble bytes MSB first: `shift <= {shift[23:0], rx_data}`.
- HEADER
  - Each rx_valid byte shifts in.
  - On the 4th byte, latch N = assembled value and clear the word index.
  - N == 0: go to DONE. Otherwise go to DATA.
- DATA
  - Each rx_valid byte shifts in.
  - On the 4th byte of a word, register `w_data` = assembled word and `addr` = word index.
  - Pulse `we` only if index ≤ CODE_SIZE. Otherwise suppress `we` and set `overflow`.
  - Increment the index.
  - When the index reaches N, go to DONE.
- DONE
  - rx_valid is ignored; no further writes.
  - `done` = 1, `busy` = 0.
- The byte counter resets to 0 at every word boundary and at the HEADER→DATA transition.
- Width rules
  - Word index and N are 32-bit unsigned.
  - Index compare is `index + 1 == N`, evaluated on the 4th byte.
  - `addr` is the zero-extended index; no wrap is possible before N is reached.
- Reset values: state = HEADER, byte counter = 0, shift = 0, N = 0, index = 0, we = 0, addr = 0, w_data = 0, busy = 0, done = 0, overflow = 0.
- Reset mid-load: the partial word and count are discarded and the FSM returns to HEADER. Words already written stay in memory.

## Timing

- rx_valid may be asserted on consecutive cycles (back-to-back bytes). No backpressure exists; every strobe must be consumed in its cycle.
- Write latency: the 4th byte of a word, sampled on edge t, gives `we` = 1 with valid `addr`/`w_data` in the cycle after edge t (registered outputs).
- `we` is high for exactly one cycle.
- `addr`/`w_data` hold their value until the next word completes.
- `busy` rises the cycle after the first header byte is sampled.
- `done`:
  - Rises on the same edge that registers the last `we` pulse, so `done` and the final `we` are high in the same cycle.
  - For N == 0, `done` rises the cycle after the 4th header byte.
  - `busy` falls on the edge where `done` rises.
- `overflow` rises with the first suppressed write and stays high.
- Maximum write rate is one word per 4 cycles; the code memory's single-cycle synchronous write absorbs it.

## Test plan

- **Basic load.** Send header 00 00 00 02, then DE AD BE EF and 12 34 56 78, back-to-back.
  - Writes (addr 0, 0xDEADBEEF) and (addr 1, 0x12345678).
  - Each `we` is one cycle, the cycle after the 4th byte.
  - `done` = 1 with the second `we`.
- **Empty program.** Send header 00 00 00 00.
  - No `we` pulses.
  - `done` = 1 the cycle after the 4th byte; `busy` = 0.
- **Gapped bytes and ignore-after-done.** Send bytes with 0–7 idle cycles between strobes, N = 3, three words.
  - Exactly three writes, at addr 0/1/2, with correct data.
  - 8 extra bytes after `done` produce no `we` and no change to `addr`/`w_data`.
- **Overflow.** With CODE_SIZE = 3, send N = 6 and six words.
  - Writes at addr 0–3 only.
  - `overflow` rises when the 5th word completes.
  - `done` rises when the 6th word completes, with no `we`.
- **Reset mid-word.** Send header N = 2, a full word, then 2 bytes of the second word; assert `rst` for 1 cycle.
  - All outputs return to 0.
  - A fresh header N = 1 plus word 0xCAFEF00D writes addr 0 = 0xCAFEF00D, then `done`.

Source files
------------

// File: rtl/code_loader.sv
// Boot-time program loader: assembles a big-endian word count and then that many
// big-endian instruction words from a UART byte stream, and writes them to code
// memory at consecutive word addresses starting from 0.
module code_loader #(
    parameter int unsigned CODE_SIZE = 32767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] w_data,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {
        HEADER,
        DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  byte_cnt;
    // Only the low 24 bits of the 32-bit assembly register are ever read back;
    // the top byte would be shifted out before anyone looks at it.
    logic [23:0] shift;
    logic [31:0] word_count;
    logic [31:0] index;

    logic [31:0] assembled;
    logic        word_end;
    logic        last_word;

    assign assembled = {shift, rx_data};
    assign word_end  = rx_valid && (byte_cnt == 2'd3);
    assign last_word = (index + 32'd1) == word_count;
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: header completes into DATA (or DONE for an empty
    // program); the last data word completes into DONE.
    always_comb begin
        state_next = state;
        case (state)
            HEADER: begin
                if (word_end) begin
                    state_next = (assembled == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (word_end && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = HEADER;
            end
        endcase
    end

    // Byte assembly, word-count latch, write strobe and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            shift      <= '0;
            word_count <= '0;
            index      <= '0;
            we         <= 1'b0;
            addr       <= '0;
            w_data     <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            we <= 1'b0;

            if (rx_valid && state != DONE) begin
                shift    <= assembled[23:0];
                byte_cnt <= word_end ? 2'd0 : byte_cnt + 2'd1;
            end

            case (state)
                HEADER: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                    end
                    if (word_end) begin
                        word_count <= assembled;
                        index      <= '0;
                        if (assembled == '0) begin
                            busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (word_end) begin
                        w_data <= assembled;
                        addr   <= index;
                        if (index <= 32'(CODE_SIZE)) begin
                            we <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        index <= index + 32'd1;
                        if (last_word) begin
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
